silu_out_packer: RTL

- Downstream stage of the silu activation unit.
- Consumes silu's non-backpressured bf16 result stream, where each element sits in result_tdata[31:16].
- Packs two consecutive bf16 elements into one 32-bit little-endian word and buffers the words in a FIFO.
- Presents the words as a ready/valid stream with a frame-end marker to the writeback/DMA path.

---
 rtl/silu_out_packer.sv | 116 +++++++++++
 1 files changed

// File: rtl/silu_out_packer.sv
// Packs pairs of bf16 silu results into 32-bit little-endian words and streams them
// out through a first-word-fall-through FIFO with a frame-end marker.
module silu_out_packer #(
    parameter int FRAME_LEN  = 49152,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_tvalid,
    input  logic [31:0]                   in_tdata,
    output logic                          m_tvalid,
    output logic [31:0]                   m_tdata,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [LW-1:0]    FULL_LVL = LW'(FIFO_DEPTH);

    logic [32:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [15:0]      half_q, half_d;
    logic             half_valid_q, half_valid_d;
    logic             overflow_q, overflow_d;
    logic             frame_done_q, frame_done_d;

    logic [15:0] elem;
    logic [32:0] head;
    logic [32:0] push_entry;
    logic        is_last, push, pop, full, push_ok;
    logic        unused_low;

    assign unused_low = ^in_tdata[15:0];
    assign elem       = in_tdata[31:16];
    assign is_last    = (elem_cnt_q == LAST_IDX);
    assign head       = mem_q[rd_ptr_q];
    assign full       = (level_q == FULL_LVL);
    assign push       = in_tvalid && (is_last || half_valid_q);
    assign pop        = m_tvalid && m_tready;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push_ok    = push && (!full || pop);
    assign push_entry = half_valid_q ? {is_last, elem, half_q} : {is_last, 16'h0000, elem};

    // Outputs are gated by occupancy so reset zeroes them even though the RAM is not cleared.
    assign m_tvalid   = (level_q != '0);
    assign m_tdata    = m_tvalid ? head[31:0] : 32'h0;
    assign m_tlast    = m_tvalid && head[32];
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

    always_comb begin
        elem_cnt_d   = elem_cnt_q;
        half_d       = half_q;
        half_valid_d = half_valid_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q | (push && !push_ok);
        frame_done_d = pop && head[32];

        if (in_tvalid) begin
            elem_cnt_d = is_last ? '0 : elem_cnt_q + 1'b1;
            if (!is_last && !half_valid_q) begin
                half_d       = elem;
                half_valid_d = 1'b1;
            end else begin
                half_valid_d = 1'b0;
            end
        end

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem_cnt_q   <= '0;
            half_q       <= '0;
            half_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            elem_cnt_q   <= elem_cnt_d;
            half_q       <= half_d;
            half_valid_q <= half_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule
